mprj_wb_mailbox: RTL and testbench

Wishbone classic responder on the user-project side of the management SoC's exported `mprj_*` bus. It gives the CPU a memory-mapped mailbox: a TX FIFO carrying words from the CPU to user logic over a valid/ready stream, and an RX FIFO carrying words from user logic back to the CPU. It also provides status and sticky error flags, plus one level interrupt that the integrator routes to a user IRQ line.

---
 rtl/mprj_wb_mailbox.sv | 198 +++++++++++++++++++
 tb/tb_mprj_wb_mailbox.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_wb_mailbox.sv
// mprj_wb_mailbox: Wishbone classic responder that exposes a CPU mailbox.
// It has a TX FIFO (CPU -> user logic stream) and an RX FIFO (user logic
// stream -> CPU), status and sticky error flags, and one level interrupt.
//
// Stream handshake: a word moves on every rising edge where valid and ready
// are both high. The source holds valid and data stable until that edge.
// The sink may raise or drop ready at any time. m_tvalid is never gated by
// m_tready, and s_tready is never gated by s_tvalid.
module mprj_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        irq_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_TXDATA = 6'h02;
    localparam logic [5:0] REG_RXDATA = 6'h03;

    // Registered state
    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_count, rx_count;
    logic          rx_irq_en, tx_irq_en;
    logic          tx_ovf, rx_udf;

    // Next-state values
    logic [AW-1:0] tx_wr_ptr_nxt, tx_rd_ptr_nxt, rx_wr_ptr_nxt, rx_rd_ptr_nxt;
    logic [CW-1:0] tx_count_nxt, rx_count_nxt;
    logic          rx_irq_en_nxt, tx_irq_en_nxt;
    logic          tx_ovf_nxt, rx_udf_nxt;
    logic          irq_nxt;

    // Bus decode
    logic [5:0]  reg_off;
    logic        hit, acc, wr_acc, rd_acc;
    logic        ctrl_wr, flush, sts_wr, tx_wr, rx_rd;
    logic [31:0] rd_data;

    // FIFO flags and transfer strobes
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    // Address bits below word granularity and the upper byte enables
    // carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

    assign reg_off = wbs_adr_i[7:2];
    assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // The !ack term turns a held strobe into one access every two cycles.
    assign acc     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr_acc  = acc & wbs_we_i;
    assign rd_acc  = acc & ~wbs_we_i;

    // Only byte 0 of CTRL holds anything, so sel[0] gates the whole update.
    assign ctrl_wr = wr_acc & (reg_off == REG_CTRL) & wbs_sel_i[0];
    assign flush   = ctrl_wr & wbs_dat_i[2];
    assign sts_wr  = wr_acc & (reg_off == REG_STATUS);
    assign tx_wr   = wr_acc & (reg_off == REG_TXDATA);
    assign rx_rd   = rd_acc & (reg_off == REG_RXDATA);

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    // A push into a full TX FIFO is dropped even if the stream pops on the
    // same edge; the registered full flag alone decides.
    assign tx_push  = tx_wr & ~tx_full;
    assign tx_pop   = m_tvalid & m_tready;
    assign rx_push  = s_tvalid & s_tready;
    assign rx_pop   = rx_rd & ~rx_empty;

    assign m_tvalid = ~tx_empty;
    assign m_tdata  = m_tvalid ? tx_mem[tx_rd_ptr] : '0;
    assign s_tready = ~rx_full & ~wb_rst_i;

    // Next-state for pointers, counts, control and sticky flags; flush wins.
    always_comb begin
        tx_wr_ptr_nxt = tx_wr_ptr;
        tx_rd_ptr_nxt = tx_rd_ptr;
        rx_wr_ptr_nxt = rx_wr_ptr;
        rx_rd_ptr_nxt = rx_rd_ptr;
        tx_count_nxt  = tx_count;
        rx_count_nxt  = rx_count;
        rx_irq_en_nxt = rx_irq_en;
        tx_irq_en_nxt = tx_irq_en;
        tx_ovf_nxt    = (tx_ovf & ~(sts_wr & wbs_dat_i[18])) | (tx_wr & tx_full);
        rx_udf_nxt    = (rx_udf & ~(sts_wr & wbs_dat_i[19])) | (rx_rd & rx_empty);
        if (ctrl_wr) begin
            rx_irq_en_nxt = wbs_dat_i[0];
            tx_irq_en_nxt = wbs_dat_i[1];
        end
        if (flush) begin
            tx_wr_ptr_nxt = '0;
            tx_rd_ptr_nxt = '0;
            rx_wr_ptr_nxt = '0;
            rx_rd_ptr_nxt = '0;
            tx_count_nxt  = '0;
            rx_count_nxt  = '0;
        end else begin
            if (tx_push) tx_wr_ptr_nxt = tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr_nxt = tx_rd_ptr + AW'(1);
            if (rx_push) rx_wr_ptr_nxt = rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr_nxt = rx_rd_ptr + AW'(1);
            tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
            rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);
        end
        irq_nxt = (rx_irq_en_nxt & (rx_count_nxt != '0)) |
                  (tx_irq_en_nxt & (tx_count_nxt == '0));
    end

    // Read mux; the RX head is sampled before the pop on the same edge.
    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_CTRL: begin
                rd_data[0] = rx_irq_en;
                rd_data[1] = tx_irq_en;
            end
            REG_STATUS: begin
                rd_data[4:0]  = 5'(tx_count);
                rd_data[12:8] = 5'(rx_count);
                rd_data[16]   = tx_full;
                rd_data[17]   = rx_empty;
                rd_data[18]   = tx_ovf;
                rd_data[19]   = rx_udf;
            end
            REG_RXDATA: begin
                if (!rx_empty) rd_data = rx_mem[rx_rd_ptr];
            end
            default: rd_data = '0;
        endcase
    end

    // Control/status/pointer registers and the registered bus response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_count  <= '0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            irq_o     <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            tx_wr_ptr <= tx_wr_ptr_nxt;
            tx_rd_ptr <= tx_rd_ptr_nxt;
            rx_wr_ptr <= rx_wr_ptr_nxt;
            rx_rd_ptr <= rx_rd_ptr_nxt;
            tx_count  <= tx_count_nxt;
            rx_count  <= rx_count_nxt;
            rx_irq_en <= rx_irq_en_nxt;
            tx_irq_en <= tx_irq_en_nxt;
            tx_ovf    <= tx_ovf_nxt;
            rx_udf    <= rx_udf_nxt;
            irq_o     <= irq_nxt;
            wbs_ack_o <= acc;
            wbs_dat_o <= rd_acc ? rd_data : '0;
        end
    end

    // FIFO storage; contents need no reset because the pointers define them.
    always_ff @(posedge wb_clk_i) begin
        if (tx_push && !flush) tx_mem[tx_wr_ptr] <= wbs_dat_i;
        if (rx_push && !flush) rx_mem[rx_wr_ptr] <= s_tdata;
    end

endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Directed bench for mprj_wb_mailbox: table of single register accesses,
// then hand-written sequences for the FIFO, flush and timing corner cases.
module tb_mprj_wb_mailbox;

    localparam logic [31:0] BASE       = 32'h3000_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_STATUS   = BASE + 32'h04;
    localparam logic [31:0] A_TXDATA   = BASE + 32'h08;
    localparam logic [31:0] A_RXDATA   = BASE + 32'h0C;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        irq;

    mprj_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .irq_o     (irq)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One classic Wishbone access; returns the ack-cycle data and how many
    // cycles after the strobe the ack came (0 when it never came).
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic acked, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        acked = 1'b0; rd = '0; lat = 0;
        for (int n = 1; n <= 16 && !acked; n++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1; rd = dat_r; lat = n;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic acked; int lat;
        wb_xfer(1'b1, a, d, 4'hF, rd, acked, lat);
        check({name, "_ack"}, 32'(acked), 32'd1);
    endtask

    task automatic wb_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic acked; int lat;
        wb_xfer(1'b0, a, '0, 4'hF, rd, acked, lat);
        check({name, "_ack"}, 32'(acked), 32'd1);
        check(name, rd, exp);
    endtask

    task automatic rx_push_word(input logic [31:0] d);
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = d;
        check("rx_push_ready", 32'(s_tready), 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    // Drains exp_q.size() beats with m_tready high, checking order.
    task automatic tx_drain(input string name);
        int n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_valid"}, 32'(m_tvalid), 32'd1);
            check({name, "_data"}, m_tdata, exp_q.pop_front());
            m_tready = 1'b1;
            @(negedge clk);
        end
        m_tready = 1'b0;
        check({name, "_empty"}, 32'(m_tvalid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        acked;
        int          lat;

        vecs.push_back('{1'b0, A_STATUS,        32'h0,          4'hF, 32'h0002_0000, "status_idle"});
        vecs.push_back('{1'b0, A_CTRL,          32'h0,          4'hF, 32'h0,         "ctrl_reset"});
        vecs.push_back('{1'b1, A_CTRL,          32'hFFFF_FFF8,  4'hF, 32'h0,         "ctrl_wr_hi"});
        vecs.push_back('{1'b0, A_CTRL,          32'h0,          4'hF, 32'h0,         "ctrl_hi_ignored"});
        vecs.push_back('{1'b1, A_CTRL,          32'h3,          4'hE, 32'h0,         "ctrl_wr_nosel"});
        vecs.push_back('{1'b0, A_CTRL,          32'h0,          4'hF, 32'h0,         "ctrl_sel_honoured"});
        vecs.push_back('{1'b1, A_CTRL,          32'h3,          4'h1, 32'h0,         "ctrl_wr_3"});
        vecs.push_back('{1'b0, A_CTRL,          32'h0,          4'hF, 32'h3,         "ctrl_rd_3"});
        vecs.push_back('{1'b1, A_CTRL,          32'h0,          4'h1, 32'h0,         "ctrl_wr_0"});
        vecs.push_back('{1'b0, A_TXDATA,        32'h0,          4'hF, 32'h0,         "txdata_rd_zero"});
        vecs.push_back('{1'b0, BASE + 32'h10,   32'h0,          4'hF, 32'h0,         "reserved_rd"});
        vecs.push_back('{1'b1, BASE + 32'h20,   32'hDEAD_BEEF,  4'hF, 32'h0,         "reserved_wr"});
        vecs.push_back('{1'b1, A_RXDATA,        32'h1234,       4'hF, 32'h0,         "rxdata_wr"});
        vecs.push_back('{1'b0, A_STATUS,        32'h0,          4'hF, 32'h0002_0000, "status_unchanged"});

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_s_tready_after", 32'(s_tready), 32'd1);

        // ---- first STATUS read: latency and one-cycle ack ----
        wb_xfer(1'b0, A_STATUS, '0, 4'hF, rd, acked, lat);
        check("first_status", rd, 32'h0002_0000);
        check("first_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("dat_zero_after_ack", dat_r, 32'd0);

        // ---- table-driven register accesses ----
        foreach (vecs[i]) begin
            wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, acked, lat);
            check({vecs[i].name, "_ack"}, 32'(acked), 32'd1);
            if (!vecs[i].w) check(vecs[i].name, rd, vecs[i].exp);
        end

        // ---- TX fill, overflow, drain ----
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            wb_write("tx_fill", A_TXDATA, 32'h11 + 32'(i));
            exp_q.push_back(32'h11 + 32'(i));
        end
        wb_read("tx_full_status", A_STATUS, 32'h0003_0008);
        wb_write("tx_ovf_push", A_TXDATA, 32'h99);
        wb_read("tx_ovf_status", A_STATUS, 32'h0007_0008);
        tx_drain("tx_stream");
        wb_write("w1c_ovf", A_STATUS, 32'h0004_0000);
        wb_read("w1c_ovf_status", A_STATUS, 32'h0002_0000);

        // ---- RX fill with interrupt, drain, underflow ----
        wb_write("ctrl_rx_irq", A_CTRL, 32'h1);
        check("irq_rx_empty", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = 32'hA0 + 32'(i);
            check("rx_fill_ready", 32'(s_tready), 32'd1);
        end
        @(negedge clk);
        s_tdata = 32'hEE;
        check("rx_full_ready", 32'(s_tready), 32'd0);
        check("rx_irq_high", 32'(irq), 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        wb_read("rx_full_status", A_STATUS, 32'h0000_0800);
        for (int i = 0; i < 8; i++) wb_read("rx_pop", A_RXDATA, 32'hA0 + 32'(i));
        wb_read("rx_udf_pop", A_RXDATA, 32'h0);
        check("rx_irq_low", 32'(irq), 32'd0);
        wb_read("rx_udf_status", A_STATUS, 32'h000A_0000);
        wb_write("w1c_both", A_STATUS, 32'h000C_0000);
        wb_read("w1c_both_status", A_STATUS, 32'h0002_0000);

        // ---- TX-empty interrupt ----
        wb_write("ctrl_tx_irq", A_CTRL, 32'h2);
        @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);
        wb_write("ctrl_off", A_CTRL, 32'h0);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);

        // ---- outside the window ----
        wb_xfer(1'b1, BASE + 32'h100, 32'h4, 4'hF, rd, acked, lat);
        check("oow_no_ack", 32'(acked), 32'd0);
        wb_read("oow_no_effect", A_STATUS, 32'h0002_0000);

        // ---- flush with same-edge stream transfers ----
        wb_read("pre_flush_udf", A_RXDATA, 32'h0);
        wb_write("pre_flush_tx", A_TXDATA, 32'h71);
        wb_write("pre_flush_tx", A_TXDATA, 32'h72);
        wb_write("pre_flush_tx", A_TXDATA, 32'h73);
        rx_push_word(32'hB0);
        rx_push_word(32'hB1);
        wb_read("pre_flush_status", A_STATUS, 32'h0008_0203);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; dat_w = 32'h4; sel = 4'h1;
        s_tvalid = 1'b1; s_tdata = 32'hBB; m_tready = 1'b1;
        @(negedge clk);
        check("flush_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        check("flush_m_tvalid", 32'(m_tvalid), 32'd0);
        wb_read("flush_status", A_STATUS, 32'h000A_0000);
        wb_read("flush_ctrl_rd", A_CTRL, 32'h0);
        wb_write("post_flush_tx", A_TXDATA, 32'h55);
        check("push_valid_latency", 32'(m_tvalid), 32'd1);
        check("push_data", m_tdata, 32'h55);
        exp_q.delete();
        exp_q.push_back(32'h55);
        tx_drain("post_flush_drain");
        rx_push_word(32'hCC);
        wb_read("rx_after_flush", A_RXDATA, 32'hCC);
        wb_write("w1c_udf", A_STATUS, 32'h0008_0000);
        wb_read("w1c_udf_status", A_STATUS, 32'h0002_0000);

        // ---- simultaneous TX push and stream pop at count 4 ----
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            wb_write("simul_fill", A_TXDATA, 32'h61 + 32'(i));
            exp_q.push_back(32'h61 + 32'(i));
        end
        @(negedge clk);
        check("simul_head", m_tdata, exp_q.pop_front());
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TXDATA; dat_w = 32'h65; sel = 4'hF;
        m_tready = 1'b1;
        exp_q.push_back(32'h65);
        @(negedge clk);
        check("simul_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; m_tready = 1'b0;
        wb_read("simul_status", A_STATUS, 32'h0002_0004);
        tx_drain("simul_drain");

        // ---- held strobe: one access per two cycles, no duplicate pops ----
        rx_push_word(32'hD0);
        rx_push_word(32'hD1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RXDATA; sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 0) check("held_d0", dat_r, 32'hD0);
            if (k == 2) check("held_d1", dat_r, 32'hD1);
        end
        cyc = 1'b0; stb = 1'b0;
        wb_read("held_status", A_STATUS, 32'h0002_0000);

        // ---- reset during a transaction ----
        wb_write("pre_rst_tx", A_TXDATA, 32'h77);
        wb_write("pre_rst_ctrl", A_CTRL, 32'h3);
        check("pre_rst_valid", 32'(m_tvalid), 32'd1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_s_tready", 32'(s_tready), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        wb_read("rst_mid_status", A_STATUS, 32'h0002_0000);
        wb_read("rst_mid_ctrl", A_CTRL, 32'h0);

        // ---- final report ----
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
